// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding, parity codes
// and the parity-bit helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  // Narrower words are zero-extended by the caller; zeros leave the XOR unchanged.
  function automatic logic parity_bit(input logic [1:0] sel, input logic [7:0] data);
    case (sel)
      PAR_ODD:  return ~^data;
      PAR_EVEN: return ^data;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/baud_tick_det.sv
// Rising-edge detector on the baud generator square wave; one tick per bit period.
module baud_tick_det (
  input  logic clock,
  input  logic reset,
  input  logic baud_in,
  output logic tick
);

  logic baud_q;

  always_ff @(posedge clock) begin
    if (reset) baud_q <= 1'b0;
    else       baud_q <= baud_in;
  end

  assign tick = baud_in & ~baud_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// one or two stop bits, paced by rising edges of the baud generator output.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud_in,
  input  logic [1:0]           parity_sel,
  input  logic                 stop_two,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_line,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned        IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_t          state;
  logic                 tick;
  logic [DATA_BITS-1:0] data_q;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_cnt;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 stop_two_q;

  baud_tick_det u_tick (
    .clock   (clock),
    .reset   (reset),
    .baud_in (baud_in),
    .tick    (tick)
  );

  assign tx_ready = (state == IDLE);
  assign tx_busy  = ~tx_ready;

  // Parity is resolved at accept time so the data register can shift out in place.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tx_line    <= 1'b1;
      tx_done    <= 1'b0;
      data_q     <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_two_q <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx_line <= 1'b1;
          if (tx_valid && tx_ready) begin
            data_q     <= tx_data;
            par_en_q   <= (parity_sel != PAR_NONE);
            par_bit_q  <= parity_bit(parity_sel, 8'(tx_data));
            stop_two_q <= stop_two;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            state      <= SYNC;
          end
        end
        SYNC: if (tick) begin
          tx_line <= 1'b0;
          state   <= START;
        end
        START: if (tick) begin
          tx_line <= data_q[0];
          bit_idx <= '0;
          state   <= DATA;
        end
        DATA: if (tick) begin
          if (bit_idx < LAST_IDX) begin
            bit_idx <= bit_idx + 1'b1;
            data_q  <= data_q >> 1;
            tx_line <= data_q[1];
          end else if (par_en_q) begin
            tx_line <= par_bit_q;
            state   <= PARITY;
          end else begin
            tx_line <= 1'b1;
            state   <= STOP;
          end
        end
        PARITY: if (tick) begin
          tx_line <= 1'b1;
          state   <= STOP;
        end
        STOP: if (tick) begin
          if (stop_cnt == stop_two_q) begin
            tx_done <= 1'b1;
            state   <= IDLE;
          end else begin
            stop_cnt <= 1'b1;
          end
        end
        default: begin
          tx_line <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8-bit and 5-bit instances driven from one baud wave
// with an 8-clock bit period; each bit is sampled mid-period.
module tb_uart_tx;

  logic       clock = 1'b0;
  logic       baud  = 1'b0;
  logic       reset;
  logic [1:0] parity_sel;
  logic       stop_two;
  logic [7:0] tx_data8;
  logic [4:0] tx_data5;
  logic       tx_valid8, tx_valid5;
  logic       ready8, line8, busy8, done8;
  logic       ready5, line5, busy5, done5;

  logic sel5 = 1'b0;
  logic obs_line, obs_ready, obs_busy, obs_done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5  clock = ~clock;
  always #40 baud  = ~baud;

  uart_tx #(.DATA_BITS(8)) dut8 (
    .clock(clock), .reset(reset), .baud_in(baud), .parity_sel(parity_sel),
    .stop_two(stop_two), .tx_data(tx_data8), .tx_valid(tx_valid8),
    .tx_ready(ready8), .tx_line(line8), .tx_busy(busy8), .tx_done(done8)
  );

  uart_tx #(.DATA_BITS(5)) dut5 (
    .clock(clock), .reset(reset), .baud_in(baud), .parity_sel(parity_sel),
    .stop_two(stop_two), .tx_data(tx_data5), .tx_valid(tx_valid5),
    .tx_ready(ready5), .tx_line(line5), .tx_busy(busy5), .tx_done(done5)
  );

  assign obs_line  = sel5 ? line5  : line8;
  assign obs_ready = sel5 ? ready5 : ready8;
  assign obs_busy  = sel5 ? busy5  : busy8;
  assign obs_done  = sel5 ? done5  : done8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word for a single cycle on the selected instance.
  task automatic send(input logic [7:0] data, input logic [1:0] par, input logic two);
    chk("ready_before_send", obs_ready, 1);
    tx_data8   = data;
    tx_data5   = data[4:0];
    parity_sel = par;
    stop_two   = two;
    if (sel5) tx_valid5 = 1'b1; else tx_valid8 = 1'b1;
    @(negedge clock);
    tx_valid8 = 1'b0;
    tx_valid5 = 1'b0;
    chk("busy_after_accept", obs_busy, 1);
  endtask

  // Returns at the negedge right after the start-bit edge.
  task automatic wait_start(input string tag);
    int waited = 0;
    while (obs_line !== 1'b0 && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    chk($sformatf("%s_start_seen", tag), (waited < 40) ? 1 : 0, 1);
  endtask

  // bits[0] is the start bit; done must pulse exactly nbits periods after it.
  task automatic check_frame(input string tag, input logic [11:0] bits, input int nbits);
    wait_start(tag);
    for (int k = 0; k < nbits; k++) begin
      repeat ((k == 0) ? 4 : 8) @(negedge clock);
      chk($sformatf("%s_bit%0d", tag, k), obs_line, bits[k]);
    end
    repeat (3) @(negedge clock);
    chk($sformatf("%s_done_early", tag), obs_done, 0);
    @(negedge clock);
    chk($sformatf("%s_done", tag), obs_done, 1);
    chk($sformatf("%s_ready_at_done", tag), obs_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    parity_sel = 2'b00;
    stop_two   = 1'b0;
    tx_data8   = 8'h00;
    tx_data5   = 5'h00;
    tx_valid8  = 1'b0;
    tx_valid5  = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_line",  line8,  1);
    chk("rst_ready", ready8, 1);
    chk("rst_busy",  busy8,  0);
    chk("rst_done",  done8,  0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_line5", line5, 1);

    // Basic frame; tx_data changes mid-frame without effect
    send(8'hA5, 2'b00, 1'b0);
    tx_data8 = 8'hFF;
    check_frame("basic", {2'b00, 1'b1, 8'hA5, 1'b0}, 10);
    @(negedge clock);
    chk("basic_done_pulse_end", obs_done, 0);

    // Parity: A5 has four ones -> even 0, odd 1, mark 1
    send(8'hA5, 2'b10, 1'b0);
    check_frame("par_even", {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
    send(8'hA5, 2'b01, 1'b0);
    check_frame("par_odd", {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11);
    send(8'hA5, 2'b11, 1'b0);
    check_frame("par_mark", {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11);

    // Two stop bits
    send(8'h00, 2'b00, 1'b1);
    check_frame("stop2", {1'b0, 2'b11, 8'h00, 1'b0}, 11);

    // Back-to-back with tx_valid held high
    tx_data8   = 8'h55;
    parity_sel = 2'b00;
    stop_two   = 1'b0;
    tx_valid8  = 1'b1;
    @(negedge clock);
    tx_data8 = 8'hAA;
    check_frame("b2b_first", {2'b00, 1'b1, 8'h55, 1'b0}, 10);
    chk("b2b_valid_at_done", tx_valid8, 1);
    @(negedge clock);
    tx_valid8 = 1'b0;
    chk("b2b_accept_in_done_cycle", busy8, 1);
    chk("b2b_gap_high_a", line8, 1);
    repeat (6) @(negedge clock);
    chk("b2b_gap_high_b", line8, 1);
    @(negedge clock);
    chk("b2b_start_exact", line8, 0);
    check_frame("b2b_second", {2'b00, 1'b1, 8'hAA, 1'b0}, 10);

    // Reset during data bit 3
    send(8'h00, 2'b00, 1'b0);
    wait_start("rst_mid");
    repeat (36) @(negedge clock);
    chk("rst_mid_bit3_low", line8, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_mid_line",  line8,  1);
    chk("rst_mid_busy",  busy8,  0);
    chk("rst_mid_done",  done8,  0);
    chk("rst_mid_ready", ready8, 1);
    repeat (2) @(negedge clock);
    send(8'h3C, 2'b01, 1'b0);
    check_frame("after_rst", {1'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);

    // Five-bit instance
    sel5 = 1'b1;
    @(negedge clock);
    send(8'h13, 2'b00, 1'b0);
    check_frame("bits5", {5'b00000, 1'b1, 5'b10011, 1'b0}, 7);
    chk("bits5_other_idle", line8, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
